ps2_key_sequencer: RTL and testbench
====================================

// Module: ps2_key_sequencer
// PURPOSE
//  Single-clock PS/2 keyboard front-end and key-event controller. Oversamples PS2Clk/datain,
//  assembles and checks 11-bit frames, and runs the make/break/extended decode FSM.
//  Drives the 6-digit display shift register with push/delete commands and a shift level.
//  Hands completed make codes to a consumer via a valid/ready handshake.
//  Sits between the keyboard pins and the display shift register/decoder chain.
// PARAMETERS
//  SYNC_STAGES     2      synchronizer depth on PS2Clk and datain (>=2)
//  TIMEOUT_CYCLES  50000  FPGAClk cycles of bus inactivity that abort a partial frame (PS2_TIMEOUT_EN only)
// PORTS
//  FPGAClk    in   1  system clock; sole clock of the block
//  rst        in   1  asynchronous, active-low reset
//  PS2Clk     in   1  raw keyboard clock (async, sampled only)
//  datain     in   1  raw keyboard data (async, sampled only)
//  key        out  8  last accepted make code (E0-prefixed codes have key[7] forced to 1)
//  key_valid  out  1  key holds an undelivered event
//  key_ready  in   1  consumer accepts key when key_valid & key_ready
//  shren      out  1  1-cycle pulse: push key into display shift register
//  del        out  1  1-cycle pulse: delete last digit (backspace make, 0x66)
//  shift      out  1  level: 1 while either shift key (0x12/0x59) is held
//  parity_err out  1  1-cycle pulse: frame dropped, odd parity failed
//  frame_err  out  1  1-cycle pulse: frame dropped, start!=0 or stop!=1 (or timeout)
//  overflow   out  1  sticky: event arrived while key_valid & ~key_ready; cleared by reset only
// BEHAVIOUR
//  Reset: all outputs 0; frame FSM=IDLE, decode FSM=BASE, bit counter=0.
//  Sampling: PS2Clk/datain pass SYNC_STAGES flops; a bit is taken on the cycle a synced 1->0 edge is seen.
//  Frame FSM: IDLE -(edge, data=0)-> DATA; IDLE with data=1 on edge -> frame_err, stay IDLE.
//   DATA: 8 bits LSB first, 4-bit counter 0..7 -> PARITY -> STOP. STOP edge: data=1 & odd parity
//   -> byte_done pulse next cycle; otherwise parity_err or frame_err (frame_err wins if both), byte discarded.
//   Counter never wraps: after STOP always returns to IDLE.
//  Decode FSM (on byte_done): BASE: F0->BRK; E0->EXT; else make(b).
//   EXT: F0->EXT_BRK; else make(b|0x80) -> BASE. BRK: break(b) -> BASE. EXT_BRK: break(b|0x80) -> BASE.
//   E0 or F0 received in BRK/EXT_BRK: treated as data (no nesting).
//  make(c): 0x12/0x59 -> shift=1, no push. 0x66 -> del pulse. Other -> key<=c, key_valid=1, shren pulse.
//   Typematic repeats are forwarded as new make events.
//  break(c): 0x12/0x59 -> shift=0 only if the other shift is not held (two held-flags); others ignored.
//  Latency: shren/del/key_valid assert 2 FPGAClk cycles after the stop-bit edge is detected.
//  Handshake: key_valid stays high until the cycle after valid&ready; key is stable while valid.
//   New event with valid&~ready: key overwritten, valid stays 1, overflow<=1.
//   New event in the same cycle as valid&ready: accept and reload, valid stays 1, no overflow.
//  Reset mid-frame: immediate abort; no partial pulses; shift held-flags cleared.
// CONFIGURATION
//  PS2_TIMEOUT_EN defined: counter cleared on every synced PS2Clk edge; reaching TIMEOUT_CYCLES
//   outside IDLE -> frame FSM IDLE, frame_err pulse, decode FSM -> BASE.
//  Not defined: no counter; a partial frame waits indefinitely for edges.
// STRUCTURE
//  Package ps2_pkg: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59,
//   SC_BKSP=8'h66; typedefs frame_state_t {IDLE,DATA,PARITY,STOP}, dec_state_t {BASE,BRK,EXT,EXT_BRK}.
//  Sub-module ps2_frame_rx: synchronizer, edge detect, frame FSM, parity/timeout;
//   outputs byte, byte_done, parity_err, frame_err. Decode FSM + handshake stay in top.
// TESTING
//  Frame 0x1C, parity ok, key_ready=1 -> key=0x1C, key_valid 1 cycle, shren 1 pulse, no err.
//  1C then F0 1C -> exactly one shren; break causes no output pulses.
//  12, 1C, F0 12 -> shift=1 before 0x1C push, shift=0 after break; 12,59,F0 12 -> shift stays 1.
//  Frame 0x1C with flipped parity bit -> parity_err pulse, no shren, decode state unchanged.
//  key_ready=0, frames 0x1C then 0x32 -> key=0x32, key_valid=1, overflow=1; E0 75 -> key=0xF5.
//  PS2_TIMEOUT_EN, 4 bits then idle TIMEOUT_CYCLES -> frame_err; next full 0x66 frame -> del pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared scan-code constants and state types for the PS/2 keyboard front-end.
// Imported by ps2_frame_rx and ps2_key_sequencer.
// ---------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_BKSP   = 8'h66;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
    typedef enum logic [1:0] {BASE, BRK, EXT, EXT_BRK} dec_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// Synchronizes the raw PS/2 clock/data pins, detects falling clock edges and
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Optional bus-inactivity timeout is compiled in with `define PS2_TIMEOUT_EN.
// Ports:
//   FPGAClk    in   system clock
//   rst        in   asynchronous active-low reset
//   PS2Clk     in   raw keyboard clock
//   datain     in   raw keyboard data
//   rx_byte    out  last assembled data byte (valid with byte_done)
//   byte_done  out  1-cycle pulse: good frame received
//   parity_err out  1-cycle pulse: frame dropped on parity
//   frame_err  out  1-cycle pulse: bad start/stop or timeout
//   timeout    out  1-cycle pulse: partial frame aborted by inactivity
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       FPGAClk,
    input  logic       rst,
    input  logic       PS2Clk,
    input  logic       datain,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall_edge;
    logic                   data_bit;
    logic                   abort;
    frame_state_t           state;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   parity_bit;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_frame_rx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    // Synchronizers reset to the idle-high bus level so that leaving reset
    // never looks like a falling clock edge.
    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2Clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], datain};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall_edge = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit  = data_sync[SYNC_STAGES-1];

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          any_edge;

    assign any_edge = clk_prev ^ clk_sync[SYNC_STAGES-1];
    assign abort    = (state != IDLE) && !any_edge &&
                      (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inactivity counter only runs while a frame is in progress.
    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (any_edge || state == IDLE || abort) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Frame FSM: all status pulses are registered, so they appear the cycle
    // after the stop-bit edge is detected.
    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            byte_done  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            timeout    <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                frame_err <= 1'b1;
                timeout   <= 1'b1;
            end else if (fall_edge) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg[bit_cnt[2:0]] <= data_bit;
                        if (bit_cnt == 4'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    PARITY: begin
                        parity_bit <= data_bit;
                        state      <= STOP;
                    end
                    STOP: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        // A bad stop bit outranks a parity failure.
                        if (!data_bit) begin
                            frame_err <= 1'b1;
                        end else if (!(^{shreg, parity_bit})) begin
                            parity_err <= 1'b1;
                        end else begin
                            byte_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_key_sequencer
// PS/2 keyboard front-end plus make/break/extended key-event decoder.
// Drives display shift-register commands (shren/del), a shift level, and
// hands make codes to a consumer over a valid/ready handshake.
// Optional frame timeout is compiled in with `define PS2_TIMEOUT_EN.
// Ports:
//   FPGAClk    in   system clock
//   rst        in   asynchronous active-low reset
//   PS2Clk     in   raw keyboard clock
//   datain     in   raw keyboard data
//   key        out  last accepted make code (extended codes have bit 7 set)
//   key_valid  out  key holds an undelivered event
//   key_ready  in   consumer ready
//   shren      out  1-cycle push pulse
//   del        out  1-cycle backspace pulse
//   shift      out  level, a shift key is held
//   parity_err out  1-cycle parity drop pulse
//   frame_err  out  1-cycle framing/timeout drop pulse
//   overflow   out  sticky: event overwrote an unconsumed key
// ---------------------------------------------------------------------------
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       FPGAClk,
    input  logic       rst,
    input  logic       PS2Clk,
    input  logic       datain,
    output logic [7:0] key,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       shren,
    output logic       del,
    output logic       shift,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       timeout;
    dec_state_t dec_state;
    logic       lshift_held;
    logic       rshift_held;
    logic       make_evt;
    logic       break_evt;
    logic [7:0] code;
    logic       push;
    logic       lshift_next;
    logic       rshift_next;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .FPGAClk    (FPGAClk),
        .rst        (rst),
        .PS2Clk     (PS2Clk),
        .datain     (datain),
        .rx_byte    (rx_byte),
        .byte_done  (byte_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    // Classify the incoming byte; prefixes only move the FSM, and inside a
    // break sequence every byte (even E0/F0) is treated as the released key.
    always_comb begin
        make_evt  = 1'b0;
        break_evt = 1'b0;
        code      = rx_byte;
        if (byte_done) begin
            case (dec_state)
                BASE:    make_evt = (rx_byte != SC_BREAK) && (rx_byte != SC_EXT);
                EXT: begin
                    make_evt = (rx_byte != SC_BREAK);
                    code     = rx_byte | 8'h80;
                end
                BRK:     break_evt = 1'b1;
                EXT_BRK: begin
                    break_evt = 1'b1;
                    code      = rx_byte | 8'h80;
                end
                default: ;
            endcase
        end
    end

    assign push = make_evt && (code != SC_LSHIFT) && (code != SC_RSHIFT) &&
                  (code != SC_BKSP);

    // Two held-flags so releasing one shift key keeps shift asserted while
    // the other is still down.
    always_comb begin
        lshift_next = lshift_held;
        rshift_next = rshift_held;
        if (make_evt && code == SC_LSHIFT)  lshift_next = 1'b1;
        if (make_evt && code == SC_RSHIFT)  rshift_next = 1'b1;
        if (break_evt && code == SC_LSHIFT) lshift_next = 1'b0;
        if (break_evt && code == SC_RSHIFT) rshift_next = 1'b0;
    end

    // Decode FSM, command pulses and the key handshake register. A new event
    // always reloads key; it only flags overflow if the old one was pending
    // and not being taken this very cycle.
    always_ff @(posedge FPGAClk or negedge rst) begin
        if (!rst) begin
            dec_state   <= BASE;
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            shift       <= 1'b0;
            shren       <= 1'b0;
            del         <= 1'b0;
            key         <= '0;
            key_valid   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            shren <= 1'b0;
            del   <= 1'b0;
            if (timeout) begin
                dec_state <= BASE;
            end else if (byte_done) begin
                case (dec_state)
                    BASE: begin
                        if (rx_byte == SC_BREAK)    dec_state <= BRK;
                        else if (rx_byte == SC_EXT) dec_state <= EXT;
                    end
                    EXT:     dec_state <= (rx_byte == SC_BREAK) ? EXT_BRK : BASE;
                    default: dec_state <= BASE;
                endcase
            end
            lshift_held <= lshift_next;
            rshift_held <= rshift_next;
            shift       <= lshift_next | rshift_next;
            if (make_evt && code == SC_BKSP) del <= 1'b1;
            if (push) begin
                shren     <= 1'b1;
                key       <= code;
                key_valid <= 1'b1;
                if (key_valid && !key_ready) overflow <= 1'b1;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_sequencer
// Directed self-checking bench for ps2_key_sequencer. Frames are bit-banged
// on PS2Clk/datain; pulse monitors count output events so each scenario task
// compares deltas against hand-computed expectations. The timeout scenario is
// compiled only with `define PS2_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_ps2_key_sequencer;

    localparam int TB_TIMEOUT = 300;

    logic       FPGAClk = 1'b0;
    logic       rst = 1'b0;
    logic       PS2Clk = 1'b1;
    logic       datain = 1'b1;
    logic [7:0] key;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       shren;
    logic       del;
    logic       shift;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int stop_cycle = 0;
    int shren_cnt = 0;
    int del_cnt = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int valid_cycles = 0;
    int last_shren_cycle = 0;
    logic shift_at_shren = 1'b0;

    ps2_key_sequencer #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .FPGAClk    (FPGAClk),
        .rst        (rst),
        .PS2Clk     (PS2Clk),
        .datain     (datain),
        .key        (key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .shren      (shren),
        .del        (del),
        .shift      (shift),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 FPGAClk = ~FPGAClk;

    always @(posedge FPGAClk) cycle <= cycle + 1;

    // Pulse monitors, sampled mid-cycle.
    always @(negedge FPGAClk) begin
        if (shren) begin
            shren_cnt        <= shren_cnt + 1;
            last_shren_cycle <= cycle;
            shift_at_shren   <= shift;
        end
        if (del)        del_cnt      <= del_cnt + 1;
        if (parity_err) perr_cnt     <= perr_cnt + 1;
        if (frame_err)  ferr_cnt     <= ferr_cnt + 1;
        if (key_valid)  valid_cycles <= valid_cycles + 1;
    end

    // Drive the first nbits of a frame; nbits=11 sends the whole frame.
    task automatic send_bits(input logic [7:0] b, input bit flip_parity,
                             input bit bad_stop, input int nbits);
        logic [10:0] f;
        logic        p;
        p = ~^b;
        if (flip_parity) p = ~p;
        f = {~bad_stop, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge FPGAClk);
            datain = f[i];
            repeat (4) @(negedge FPGAClk);
            PS2Clk = 1'b0;
            if (i == 10) stop_cycle = cycle;
            repeat (8) @(negedge FPGAClk);
            PS2Clk = 1'b1;
            repeat (6) @(negedge FPGAClk);
        end
        datain = 1'b1;
        repeat (8) @(negedge FPGAClk);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b0, 11);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(negedge FPGAClk);
        checks++;
        if ({key, key_valid, shren, del, shift, parity_err, frame_err, overflow} !== 15'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h",
                     {key, key_valid, shren, del, shift, parity_err, frame_err, overflow}, 15'h0);
        end
        rst = 1'b1;
        repeat (4) @(negedge FPGAClk);
        checks++;
        if (ferr_cnt != 0 || shren_cnt != 0) begin
            errors++;
            $display("[TB] FAIL reset_release_pulses: got ferr=%0d shren=%0d expected 0 0", ferr_cnt, shren_cnt);
        end
    endtask

    task automatic test_make();
        int s0, v0, p0, f0;
        key_ready = 1'b1;
        s0 = shren_cnt; v0 = valid_cycles; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C);
        checks++;
        if (key !== 8'h1C) begin
            errors++; $display("[TB] FAIL make_key: got %h expected %h", key, 8'h1C);
        end
        checks++;
        if (shren_cnt - s0 != 1) begin
            errors++; $display("[TB] FAIL make_shren: got %0d expected 1", shren_cnt - s0);
        end
        checks++;
        if (valid_cycles - v0 != 1) begin
            errors++; $display("[TB] FAIL make_valid_cycles: got %0d expected 1", valid_cycles - v0);
        end
        checks++;
        if (last_shren_cycle - stop_cycle != 4) begin
            errors++; $display("[TB] FAIL make_latency: got %0d expected 4", last_shren_cycle - stop_cycle);
        end
        checks++;
        if (perr_cnt != p0 || ferr_cnt != f0) begin
            errors++; $display("[TB] FAIL make_no_err: got perr=%0d ferr=%0d expected %0d %0d",
                               perr_cnt, ferr_cnt, p0, f0);
        end
    endtask

    task automatic test_break();
        int s0, d0, v0;
        s0 = shren_cnt; d0 = del_cnt; v0 = valid_cycles;
        send_frame(8'hF0);
        send_frame(8'h1C);
        checks++;
        if (shren_cnt != s0 || del_cnt != d0 || valid_cycles != v0) begin
            errors++; $display("[TB] FAIL break_silent: got shren=%0d del=%0d valid=%0d expected 0 0 0",
                               shren_cnt - s0, del_cnt - d0, valid_cycles - v0);
        end
    endtask

    task automatic test_shift();
        int s0;
        s0 = shren_cnt;
        send_frame(8'h12);
        checks++;
        if (shift !== 1'b1 || shren_cnt != s0) begin
            errors++; $display("[TB] FAIL shift_make: got shift=%b shren=%0d expected 1 0", shift, shren_cnt - s0);
        end
        send_frame(8'h1C);
        checks++;
        if (shren_cnt - s0 != 1 || shift_at_shren !== 1'b1) begin
            errors++; $display("[TB] FAIL shift_push: got shren=%0d shift=%b expected 1 1",
                               shren_cnt - s0, shift_at_shren);
        end
        send_frame(8'hF0);
        send_frame(8'h12);
        checks++;
        if (shift !== 1'b0) begin
            errors++; $display("[TB] FAIL shift_release: got %b expected 0", shift);
        end
        send_frame(8'h12);
        send_frame(8'h59);
        send_frame(8'hF0);
        send_frame(8'h12);
        checks++;
        if (shift !== 1'b1) begin
            errors++; $display("[TB] FAIL shift_other_held: got %b expected 1", shift);
        end
        send_frame(8'hF0);
        send_frame(8'h59);
        checks++;
        if (shift !== 1'b0) begin
            errors++; $display("[TB] FAIL shift_both_released: got %b expected 0", shift);
        end
    endtask

    task automatic test_parity();
        int s0, p0;
        s0 = shren_cnt; p0 = perr_cnt;
        send_frame(8'hF0);
        send_bits(8'h1C, 1'b1, 1'b0, 11);
        checks++;
        if (perr_cnt - p0 != 1 || shren_cnt != s0) begin
            errors++; $display("[TB] FAIL parity_drop: got perr=%0d shren=%0d expected 1 0",
                               perr_cnt - p0, shren_cnt - s0);
        end
        send_frame(8'h1C);
        checks++;
        if (shren_cnt != s0) begin
            errors++; $display("[TB] FAIL parity_state_kept: got shren=%0d expected 0", shren_cnt - s0);
        end
        send_frame(8'h1C);
        checks++;
        if (shren_cnt - s0 != 1) begin
            errors++; $display("[TB] FAIL parity_recover: got shren=%0d expected 1", shren_cnt - s0);
        end
    endtask

    task automatic test_frame_err();
        int s0, p0, f0;
        s0 = shren_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_bits(8'h1C, 1'b0, 1'b1, 11);
        send_bits(8'h1C, 1'b1, 1'b1, 11);
        checks++;
        if (ferr_cnt - f0 != 2 || perr_cnt != p0 || shren_cnt != s0) begin
            errors++; $display("[TB] FAIL frame_err_stop: got ferr=%0d perr=%0d shren=%0d expected 2 0 0",
                               ferr_cnt - f0, perr_cnt - p0, shren_cnt - s0);
        end
    endtask

    task automatic test_del();
        int s0, d0;
        s0 = shren_cnt; d0 = del_cnt;
        send_frame(8'h66);
        checks++;
        if (del_cnt - d0 != 1 || shren_cnt != s0 || key !== 8'h1C) begin
            errors++; $display("[TB] FAIL del_pulse: got del=%0d shren=%0d key=%h expected 1 0 1c",
                               del_cnt - d0, shren_cnt - s0, key);
        end
    endtask

    task automatic test_extended();
        int s0;
        s0 = shren_cnt;
        send_frame(8'hE0);
        send_frame(8'h6B);
        checks++;
        if (key !== 8'hEB || shren_cnt - s0 != 1) begin
            errors++; $display("[TB] FAIL ext_make: got key=%h shren=%0d expected eb 1", key, shren_cnt - s0);
        end
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h6B);
        checks++;
        if (shren_cnt - s0 != 1) begin
            errors++; $display("[TB] FAIL ext_break: got shren=%0d expected 1", shren_cnt - s0);
        end
    endtask

    task automatic test_reset_midframe();
        int s0, p0, f0;
        send_frame(8'h12);
        send_bits(8'h3A, 1'b0, 1'b0, 5);
        s0 = shren_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        rst = 1'b0;
        repeat (3) @(negedge FPGAClk);
        checks++;
        if (shift !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_clears_shift: got %b expected 0", shift);
        end
        rst = 1'b1;
        repeat (4) @(negedge FPGAClk);
        send_frame(8'h1C);
        checks++;
        if (key !== 8'h1C || shren_cnt - s0 != 1 || perr_cnt != p0 || ferr_cnt != f0) begin
            errors++; $display("[TB] FAIL reset_midframe_abort: got key=%h shren=%0d perr=%0d ferr=%0d expected 1c 1 0 0",
                               key, shren_cnt - s0, perr_cnt - p0, ferr_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        key_ready = 1'b0;
        send_frame(8'h1C);
        checks++;
        if (key_valid !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("[TB] FAIL hold_first: got valid=%b overflow=%b expected 1 0", key_valid, overflow);
        end
        send_frame(8'h32);
        checks++;
        if (key !== 8'h32 || key_valid !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("[TB] FAIL overflow_second: got key=%h valid=%b overflow=%b expected 32 1 1",
                               key, key_valid, overflow);
        end
        send_frame(8'hE0);
        send_frame(8'h75);
        checks++;
        if (key !== 8'hF5) begin
            errors++; $display("[TB] FAIL ext_key_f5: got %h expected f5", key);
        end
        key_ready = 1'b1;
        repeat (2) @(negedge FPGAClk);
        checks++;
        if (key_valid !== 1'b0 || key !== 8'hF5) begin
            errors++; $display("[TB] FAIL handshake_drain: got valid=%b key=%h expected 0 f5", key_valid, key);
        end
    endtask

`ifdef PS2_TIMEOUT_EN
    task automatic test_timeout();
        int s0, d0, f0;
        key_ready = 1'b1;
        send_frame(8'hE0);
        f0 = ferr_cnt;
        send_bits(8'h55, 1'b0, 1'b0, 4);
        repeat (TB_TIMEOUT + 50) @(negedge FPGAClk);
        checks++;
        if (ferr_cnt - f0 != 1) begin
            errors++; $display("[TB] FAIL timeout_frame_err: got %0d expected 1", ferr_cnt - f0);
        end
        s0 = shren_cnt; d0 = del_cnt;
        send_frame(8'h66);
        checks++;
        if (del_cnt - d0 != 1 || shren_cnt != s0) begin
            errors++; $display("[TB] FAIL timeout_recover_del: got del=%0d shren=%0d expected 1 0",
                               del_cnt - d0, shren_cnt - s0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_make();
        test_break();
        test_shift();
        test_parity();
        test_frame_err();
        test_del();
        test_extended();
        test_reset_midframe();
        test_back_to_back();
`ifdef PS2_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
